// File: rtl/fractal_sync_nary.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_nary
// Brief    : N-ary fractal barrier node. It collects syncs from a masked
//            subset of slave ports, then either wakes them locally or
//            forwards one level up through the master port.
//            Optional arrival timeout: FRACTAL_SYNC_NARY_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
module fractal_sync_nary #(
    parameter int N_SLV     = 4,
    parameter int SLV_WIDTH = 3,
    parameter int MST_WIDTH = SLV_WIDTH - 1,
    parameter int TIMEOUT_W = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_SLV-1:0]                        part_mask_i,
    input  logic [N_SLV-1:0]                        slv_sync_i,
    input  logic [N_SLV*SLV_WIDTH-1:0]              slv_level_i,
    input  logic [N_SLV-1:0]                        slv_ack_i,
    output logic [N_SLV-1:0]                        slv_wake_o,
    output logic [N_SLV-1:0]                        slv_error_o,
    output logic                                    mst_sync_o,
    output logic [(MST_WIDTH > 0 ? MST_WIDTH : 1)-1:0] mst_level_o,
    output logic                                    mst_ack_o,
    input  logic                                    mst_wake_i,
    input  logic                                    mst_error_i,
`ifdef FRACTAL_SYNC_NARY_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0]                    timeout_i,
`endif
    output logic                                    busy_o
);

    localparam int MLW = (MST_WIDTH > 0) ? MST_WIDTH : 1;

    generate
        if (N_SLV < 2 || N_SLV > 32 || SLV_WIDTH < 1 || TIMEOUT_W < 1) begin : g_param_check
            $error("fractal_sync_nary: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROP = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [N_SLV-1:0]       r_presence;
    logic [N_SLV-1:0]       r_ack;
    logic [N_SLV-1:0]       r_need;
    logic [N_SLV-1:0]       r_wake;
    logic [N_SLV-1:0]       r_slv_err;
    logic [SLV_WIDTH-1:0]   r_level [N_SLV];
    logic                   r_err;
    logic                   r_via_prop;
    logic                   r_mst_sync;
    logic                   r_mst_ack;
    logic [MLW-1:0]         r_mst_level;

    logic [N_SLV-1:0]       w_arrive;
    logic [SLV_WIDTH-1:0]   w_lvl;
    logic [MLW-1:0]         w_up_level;
    logic                   w_found;
    logic                   w_valid;
    logic                   w_local;
    logic                   w_idle;
    logic                   w_all_present;
    logic                   w_all_acked;
    logic                   w_timeout;
    logic                   w_leave_idle;
    logic                   w_enter_prop;
    logic                   w_exit;
    logic                   w_drop;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_arrive      = {N_SLV{w_idle}} & slv_sync_i & part_mask_i & ~r_presence;
    assign w_all_present = (&(r_presence | ~part_mask_i)) && (|part_mask_i);
    assign w_all_acked   = &(r_ack | ~r_need);
    assign w_exit        = (r_state == ST_SYNC) && w_all_acked;
    assign w_leave_idle  = w_idle && (w_state_nxt != ST_IDLE);
    assign w_enter_prop  = w_idle && (w_state_nxt == ST_PROP);
    assign w_drop        = |(slv_sync_i & ~({N_SLV{w_idle}} & part_mask_i));

    // Reference level comes from the lowest-index participating port
    always_comb begin
        w_lvl   = '0;
        w_found = 1'b0;
        w_valid = 1'b1;
        for (int i = 0; i < N_SLV; i++) begin
            if (part_mask_i[i] && !w_found) begin
                w_lvl   = r_level[i];
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N_SLV; i++) begin
            if (part_mask_i[i] && (r_level[i] != w_lvl)) begin
                w_valid = 1'b0;
            end
        end
    end

    assign w_local    = (MST_WIDTH == 0) || w_lvl[0];
    assign w_up_level = MLW'(w_lvl >> 1);

`ifdef FRACTAL_SYNC_NARY_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]   r_tmo_cnt;
    logic                   r_tmo_armed;
    logic                   w_first_arrival;

    assign w_first_arrival = ((r_presence & part_mask_i) == '0) && (|w_arrive);
    assign w_timeout       = w_idle && r_tmo_armed && (r_tmo_cnt == '0) && !w_all_present;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt   <= '0;
            r_tmo_armed <= 1'b0;
        end else if (!w_idle) begin
            r_tmo_armed <= 1'b0;
        end else if (w_first_arrival) begin
            r_tmo_cnt   <= timeout_i;
            r_tmo_armed <= |timeout_i;
        end else if (r_tmo_armed && !w_all_present && (r_tmo_cnt != '0)) begin
            r_tmo_cnt   <= r_tmo_cnt - 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_all_present) begin
                    w_state_nxt = (w_local || !w_valid) ? ST_SYNC : ST_PROP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_PROP: begin
                if (mst_wake_i) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_all_acked) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presence  <= '0;
            r_ack       <= '0;
            r_need      <= '0;
            r_wake      <= '0;
            r_slv_err   <= '0;
            r_err       <= 1'b0;
            r_via_prop  <= 1'b0;
            r_mst_sync  <= 1'b0;
            r_mst_ack   <= 1'b0;
            r_mst_level <= '0;
            for (int i = 0; i < N_SLV; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_presence <= w_exit ? '0 : (r_presence | w_arrive);
            for (int i = 0; i < N_SLV; i++) begin
                if (w_arrive[i]) begin
                    r_level[i] <= slv_level_i[i*SLV_WIDTH +: SLV_WIDTH];
                end
            end

            if (w_exit) begin
                r_ack <= '0;
            end else if (r_state == ST_SYNC) begin
                r_ack <= r_ack | (slv_ack_i & r_need);
            end

            // A timed-out barrier only serves the ports that actually arrived
            if (w_leave_idle) begin
                r_need <= w_all_present ? part_mask_i : (r_presence & part_mask_i);
                r_err  <= w_all_present ? !w_valid : 1'b1;
            end else if ((r_state == ST_PROP) && mst_wake_i) begin
                r_err  <= r_err | mst_error_i;
            end else if (w_exit) begin
                r_err  <= 1'b0;
            end

            if (w_enter_prop) begin
                r_via_prop <= 1'b1;
            end else if (w_exit) begin
                r_via_prop <= 1'b0;
            end

            r_mst_sync <= w_enter_prop;
            r_mst_ack  <= w_exit && r_via_prop;

            if (w_enter_prop) begin
                r_mst_level <= w_up_level;
            end else if ((r_state == ST_PROP) && (w_state_nxt != ST_PROP)) begin
                r_mst_level <= '0;
            end

            r_wake    <= ((r_state == ST_SYNC) && !w_all_acked) ? r_need : '0;
            r_slv_err <= ((r_state == ST_SYNC) && !w_all_acked) ? {N_SLV{r_err}} : '0;
        end
    end

    assign slv_wake_o  = r_wake;
    assign slv_error_o = r_slv_err;
    assign mst_sync_o  = r_mst_sync;
    assign mst_level_o = r_mst_level;
    assign mst_ack_o   = r_mst_ack;
    assign busy_o      = !w_idle || (|r_presence);

    assert property (@(posedge clk_i) disable iff (rst_i) !w_drop)
        else $warning("fractal_sync_nary: sync dropped (port not participating or node not idle)");

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_nary.sv
`default_nettype none
// ============================================================================
// Module   : tb_fractal_sync_nary
// Brief    : Randomised barrier scenarios against a transaction-level model
//            of fractal_sync_nary (N_SLV=4, SLV_WIDTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fractal_sync_nary;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  part_mask_i = '0;
    logic [3:0]  slv_sync_i = '0;
    logic [11:0] slv_level_i = '0;
    logic [3:0]  slv_ack_i = '0;
    logic [3:0]  slv_wake_o;
    logic [3:0]  slv_error_o;
    logic        mst_sync_o;
    logic [1:0]  mst_level_o;
    logic        mst_ack_o;
    logic        mst_wake_i = 1'b0;
    logic        mst_error_i = 1'b0;
    logic        busy_o;
`ifdef FRACTAL_SYNC_NARY_TIMEOUT_EN
    logic [15:0] timeout_i = '0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_msync = 0;

    fractal_sync_nary dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .part_mask_i (part_mask_i),
        .slv_sync_i  (slv_sync_i),
        .slv_level_i (slv_level_i),
        .slv_ack_i   (slv_ack_i),
        .slv_wake_o  (slv_wake_o),
        .slv_error_o (slv_error_o),
        .mst_sync_o  (mst_sync_o),
        .mst_level_o (mst_level_o),
        .mst_ack_o   (mst_ack_o),
        .mst_wake_i  (mst_wake_i),
        .mst_error_i (mst_error_i),
`ifdef FRACTAL_SYNC_NARY_TIMEOUT_EN
        .timeout_i   (timeout_i),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mst_sync_o === 1'b1) n_msync++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wake"}, slv_wake_o, 0);
        chk({tag, "_err"}, slv_error_o, 0);
        chk({tag, "_msync"}, mst_sync_o, 0);
        chk({tag, "_mlevel"}, mst_level_o, 0);
        chk({tag, "_mack"}, mst_ack_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    // One complete barrier. lv/arr/ackd hold 3 bits per port.
    task automatic run_barrier(input logic [3:0] mask, input logic [11:0] lv,
                               input logic [11:0] arr, input bit merr, input int mdly,
                               input logic [11:0] ackd, input bit noise, input bit abort);
        int         first;
        int         last_arr;
        int         max_ack;
        int         ms0;
        logic [2:0] lvl_e;
        bit         valid_e, prop_e, err_e;
        logic [3:0] seen;
        logic [3:0] sy;
        logic [3:0] ak;
        logic [11:0] lvin;

        // Expected outcome from the barrier rules
        first = -1;
        for (int i = 0; i < 4; i++) if (mask[i] && first < 0) first = i;
        lvl_e   = lv[first*3 +: 3];
        valid_e = 1'b1;
        for (int i = 0; i < 4; i++) if (mask[i] && lv[i*3 +: 3] != lvl_e) valid_e = 1'b0;
        prop_e  = valid_e && !lvl_e[0];
        last_arr = 0;
        max_ack  = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && int'(arr[i*3 +: 3]) > last_arr) last_arr = int'(arr[i*3 +: 3]);
            if (mask[i] && int'(ackd[i*3 +: 3]) > max_ack) max_ack = int'(ackd[i*3 +: 3]);
        end

        part_mask_i = mask;
        ms0  = n_msync;
        seen = '0;
        for (int k = 0; k <= last_arr; k++) begin
            sy   = '0;
            lvin = 12'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && !seen[i] && int'(arr[i*3 +: 3]) == k) begin
                    sy[i] = 1'b1;
                    lvin[i*3 +: 3] = lv[i*3 +: 3];
                end else if (noise && $urandom_range(0, 2) == 0 && (!mask[i] || seen[i])) begin
                    sy[i] = 1'b1;
                end
            end
            slv_sync_i  = sy;
            slv_level_i = lvin;
            slv_ack_i   = noise ? 4'($urandom) : 4'b0;
            step();
            for (int i = 0; i < 4; i++) if (mask[i] && int'(arr[i*3 +: 3]) == k) seen[i] = 1'b1;
            chk("busy_arrival", busy_o, (seen != 0));
            chk("wake_arrival", slv_wake_o, 0);
        end
        slv_sync_i = '0;
        slv_ack_i  = '0;
        step();
        chk("wake_t1", slv_wake_o, 0);
        chk("msync_t1", mst_sync_o, prop_e);
        chk("busy_t1", busy_o, 1);

        if (prop_e) begin
            chk("mlevel_t1", mst_level_o, lvl_e[2:1]);
            if (abort) begin
                rst_i = 1'b1;
                step();
                rst_i = 1'b0;
                chk_all_zero("abort");
                return;
            end
            for (int d = 0; d < mdly; d++) begin
                step();
                chk("msync_hold", mst_sync_o, 0);
                chk("mlevel_hold", mst_level_o, lvl_e[2:1]);
                chk("wake_prop", slv_wake_o, 0);
            end
            mst_wake_i  = 1'b1;
            mst_error_i = merr;
            step();
            mst_wake_i  = 1'b0;
            mst_error_i = 1'b0;
            chk("wake_s0", slv_wake_o, 0);
        end

        err_e = !valid_e || (prop_e && merr);
        step();
        chk("wake_on", slv_wake_o, mask);
        chk("error_on", slv_error_o, {4{err_e}});

        for (int d = 0; d <= max_ack; d++) begin
            ak = '0;
            for (int i = 0; i < 4; i++) if (mask[i] && int'(ackd[i*3 +: 3]) == d) ak[i] = 1'b1;
            if (noise) ak = ak | (4'($urandom) & ~mask);
            slv_ack_i = ak;
            step();
            chk("wake_acking", slv_wake_o, mask);
            chk("mack_acking", mst_ack_o, 0);
        end
        slv_ack_i = '0;
        // A sync landing on the exit edge must not start a barrier
        if (noise) begin
            slv_sync_i  = mask;
            slv_level_i = 12'($urandom);
        end
        step();
        slv_sync_i = '0;
        chk("wake_exit", slv_wake_o, 0);
        chk("error_exit", slv_error_o, 0);
        chk("busy_exit", busy_o, 0);
        chk("mack_exit", mst_ack_o, prop_e);
        step();
        chk("mack_after", mst_ack_o, 0);
        chk("msync_count", n_msync - ms0, prop_e);
    endtask

    initial begin
        logic [3:0]  m;
        logic [11:0] lv, arr, ackd;
        logic [2:0]  l;

        rst_i = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst_i = 1'b0;
        step();

        // Local barrier, all at once
        run_barrier(4'b1111, {4{3'b101}}, 12'd0, 1'b0, 0, 12'd0, 1'b0, 1'b0);
        // Staggered propagation with upstream error
        run_barrier(4'b1111, {4{3'b110}}, {3'd1, 3'd4, 3'd2, 3'd0}, 1'b1, 2, {3'd0, 3'd2, 3'd1, 3'd3}, 1'b0, 1'b0);
        // Level mismatch resolves locally with error
        run_barrier(4'b1111, {3'b010, 3'b110, 3'b110, 3'b110}, {3'd0, 3'd1, 3'd0, 3'd2}, 1'b0, 0, 12'd0, 1'b0, 1'b0);
        // Partial mask with dropped syncs and ignored acks
        run_barrier(4'b0101, {3'b111, 3'b001, 3'b111, 3'b001}, {3'd0, 3'd1, 3'd0, 3'd0}, 1'b0, 0, {3'd0, 3'd1, 3'd0, 3'd2}, 1'b1, 1'b0);
        // Reset while propagating, then a clean barrier
        run_barrier(4'b1111, {4{3'b110}}, 12'd0, 1'b0, 0, 12'd0, 1'b0, 1'b1);
        run_barrier(4'b1111, {4{3'b101}}, 12'd0, 1'b0, 0, 12'd0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 0) begin
                l  = 3'($urandom);
                lv = {l, l, l, l};
            end else begin
                lv = 12'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                arr[i*3 +: 3]  = 3'($urandom_range(0, 4));
                ackd[i*3 +: 3] = 3'($urandom_range(0, 3));
            end
            run_barrier(m, lv, arr, 1'($urandom), $urandom_range(0, 3), ackd, 1'b1, 1'b0);
        end

`ifdef FRACTAL_SYNC_NARY_TIMEOUT_EN
        begin
            int  lat;
            bit  seen_wake;
            timeout_i   = 16'd10;
            part_mask_i = 4'b1111;
            slv_sync_i  = 4'b0011;
            slv_level_i = {4{3'b101}};
            step();
            slv_sync_i  = '0;
            lat = 0;
            seen_wake = 1'b0;
            for (int c = 1; c <= 30 && !seen_wake; c++) begin
                step();
                lat = c;
                if (slv_wake_o != 0) seen_wake = 1'b1;
            end
            chk("tmo_wake_seen", seen_wake, 1);
            chk("tmo_latency_ok", (lat >= 9 && lat <= 13), 1);
            chk("tmo_wake", slv_wake_o, 4'b0011);
            chk("tmo_error", slv_error_o, 4'b1111);
            slv_ack_i = 4'b0011;
            step();
            slv_ack_i = '0;
            step();
            chk("tmo_busy_exit", busy_o, 0);
            chk("tmo_wake_exit", slv_wake_o, 0);
            timeout_i = '0;
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fractal_sync_nary.md
Name: fractal_sync_nary

Overview:
- Parametrised successor of the 2-port fractal synchronisation node. It serves N_SLV slave ports with a per-port participation mask, so only the enabled subset must arrive.
- It captures and validates the barrier level. It either resolves the barrier locally or propagates one level up through the master port.
- It handles wake/ack/error handshakes with registered, Moore-style outputs.
- It sits at any node of the fractal sync tree; the root has MST_WIDTH = 0.

Parameters:
- N_SLV, 4, number of slave ports; legal range 2..32.
- SLV_WIDTH, 3, width of the level field on slave ports; must be ≥1.
- MST_WIDTH, SLV_WIDTH-1 (derived), width of the level field on the master port; 0 means root node.
- TIMEOUT_W, 16, width of the arrival-timeout counter; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- part_mask_i  in  N_SLV  participating ports; quasi-static, changed only while busy_o=0.
- slv_sync_i  in  N_SLV  per-port sync request pulse.
- slv_level_i  in  N_SLV*SLV_WIDTH  per-port level; port i at bits [i*SLV_WIDTH +: SLV_WIDTH]; valid with slv_sync_i[i].
- slv_ack_i  in  N_SLV  per-port wake acknowledge pulse.
- slv_wake_o  out  N_SLV  per-port wake.
- slv_error_o  out  N_SLV  per-port error, valid while slv_wake_o is high.
- mst_sync_o  out  1  upstream sync pulse.
- mst_level_o  out  max(MST_WIDTH,1)  upstream level.
- mst_ack_o  out  1  upstream ack pulse.
- mst_wake_i  in  1  upstream wake.
- mst_error_i  in  1  upstream error, valid with mst_wake_i.
- busy_o  out  1  FSM not in IDLE, or any presence bit set.

Behaviour:
- Reset: all presence, ack and level registers are cleared, FSM goes to IDLE, and every output is 0. Reset mid-operation abandons the barrier with no pulses emitted.

Arrival (IDLE only):
- slv_sync_i[i] with part_mask_i[i]=1 sets presence[i] and captures that port's level.
- A repeat sync from a port already present is ignored; the first level is kept.
- Syncs from non-masked ports, or any sync outside IDLE, are dropped. A simulation-only assertion fires on them.

Completion:
- all_present = &(presence | ~part_mask_i) with part_mask_i != 0, evaluated from registers.
- If the last sync is sampled at edge t, the FSM leaves IDLE at edge t+1.
- valid = all captured levels of masked ports are equal.
- local = (MST_WIDTH==0) or lvl[0]==1, where lvl is the level of the lowest-index masked port.

FSM:
- IDLE→SYNC when all_present and (local or !valid). The error flag is set to !valid.
- IDLE→PROP when all_present, !local and valid. mst_level_o = lvl[SLV_WIDTH-1:1].
- PROP: mst_sync_o is high for exactly the first cycle in PROP. mst_level_o is held for the whole state.
- PROP→SYNC on mst_wake_i; the error flag is ORed with mst_error_i.
- SYNC: slv_wake_o = part_mask_i and slv_error_o = {N_SLV{error flag}}, both registered.
- SYNC: each slv_ack_i[i] of a masked port sets a sticky ack bit.
- SYNC→IDLE the cycle after all masked acks are present.
- On that exit: one-cycle mst_ack_o pulse, only if the barrier went through PROP. Presence, ack and error flag are cleared, and wake drops.
- An ack from a non-masked port, or an ack outside SYNC, is ignored.

Timing and persistence:
- Minimum local round trip: last sync at t, wake high from t+2, ack at t+2, IDLE at t+4.
- A sync arriving in the same cycle as the SYNC→IDLE exit is dropped. The new barrier starts from the first cycle of IDLE.

Optional Feature:
Macro: FRACTAL_SYNC_NARY_TIMEOUT_EN.
- With the macro defined:
  - An added input timeout_i[TIMEOUT_W] is present.
  - A counter loads timeout_i on the first masked arrival in IDLE and decrements each cycle while all_present=0.
  - If the counter reaches 0, IDLE→SYNC with the error flag set. Only ports whose presence is set are woken, and only their acks are required.
  - timeout_i=0 disables the timeout.
- Without the macro: no port, no counter; the node waits indefinitely.

Test Plan:
- N_SLV=4, SLV_WIDTH=3, mask=4'b1111, all ports sync with level 3'b101 in the same cycle → wake=4'b1111 two cycles later, error=0, mst_sync_o never asserted; all ack → busy_o=0 after 2 cycles, mst_ack_o=0.
- Same setup, levels 3'b110 arriving staggered over 5 cycles → single mst_sync_o pulse with mst_level_o=2'b11. Hold mst_wake_i=1 and mst_error_i=1 → wake=1111 with error=1111. All ack → one mst_ack_o pulse.
- Level mismatch: ports 0-2 at 3'b110, port 3 at 3'b010 → no propagation, direct SYNC with error=1111.
- mask=4'b0101, only ports 0 and 2 sync at 3'b001 → wake=4'b0101. Sync on port 1 is dropped; ack on port 3 is ignored.
- Assert rst_i while in PROP → next cycle all outputs 0, busy_o=0. A fresh barrier then completes normally.
- With FRACTAL_SYNC_NARY_TIMEOUT_EN, timeout_i=10, only ports 0 and 1 sync → 10 cycles later wake=4'b0011 with error set; acks from ports 0 and 1 suffice to return to IDLE.
